sequence_checker: RTL and testbench

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/sequence_checker.sv | 199 +++++++++++++++++++
 tb/tb_sequence_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// Player-side checker for a memory/sequence game.
// Raw buttons are synchronised and debounced, then a small FSM walks the
// expected sequence one element per press/release. A wrong button or a
// timeout while waiting for a press ends the game until reset.
module sequence_checker #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btns,
  input  logic       start,
  input  logic [4:0] seq_len,
  output logic [3:0] seq_rd_addr,
  input  logic [1:0] seq_rd_data,
  output logic [1:0] num,
  output logic       pressed,
  output logic       busy,
  output logic       round_ok,
  output logic       game_over
);

  // Counter widths only need to hold the terminal value (N-1).
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_MAX = TM_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_FAIL
  } state_e;

  // Synchroniser and debouncer state
  logic [3:0]      sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [3:0]      stable_q;

  // Sequencing state
  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [TM_W-1:0] timer_q, timer_d;
  logic            lock_q, lock_d;
  logic [4:0]      len_q, len_d;

  // Registered outputs
  logic [1:0]      num_q, num_d;
  logic            pressed_q, pressed_d;
  logic            busy_q, busy_d;
  logic            round_ok_q, round_ok_d;
  logic            game_over_q, game_over_d;

  // Decoded debounced vector
  logic            valid_press;
  logic [1:0]      press_num;
  logic            all_released;

  // Two-flop synchroniser followed by a restart-on-change debounce counter.
  // The counter looks at sync1 vs sync2, so it restarts in the same edge the
  // synchronised value changes and the stable vector follows after exactly
  // DEBOUNCE_CYCLES unchanged cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_cnt_q <= '0;
      stable_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync1_q <= btns;
      sync2_q <= sync1_q;
      if (sync1_q != sync2_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_MAX) begin
        stable_q <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Decode the stable vector: exactly one bit set is a press.
  always_comb begin
    valid_press  = $onehot(stable_q);
    all_released = (stable_q == 4'b0000);
    unique case (stable_q)
      4'b0001: press_num = 2'd0;
      4'b0010: press_num = 2'd1;
      4'b0100: press_num = 2'd2;
      4'b1000: press_num = 2'd3;
      default: press_num = 2'd0;
    endcase
  end

  // Next-state logic for the checker FSM and its registered outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    lock_d     = lock_q;
    len_d      = len_q;
    round_ok_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (seq_len != 5'd0) && (seq_len <= 5'd16)) begin
          state_d = ST_WAIT_PRESS;
          idx_d   = '0;
          timer_d = '0;
          len_d   = seq_len;
          // A button already held at round start must be released first.
          lock_d  = !all_released;
        end
      end

      ST_WAIT_PRESS: begin
        if (lock_q && all_released) begin
          lock_d = 1'b0;
        end
        // A press in the final timer cycle still wins over the timeout.
        if (!lock_q && valid_press) begin
          state_d = (press_num == seq_rd_data) ? ST_WAIT_RELEASE : ST_FAIL;
        end else if (timer_q == TM_MAX) begin
          state_d = ST_FAIL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_WAIT_RELEASE: begin
        // Only an all-zero vector is a release; multi-button keeps waiting.
        if (all_released) begin
          if ({1'b0, idx_q} == (len_q - 5'd1)) begin
            state_d    = ST_IDLE;
            round_ok_d = 1'b1;
          end else begin
            state_d = ST_WAIT_PRESS;
            idx_d   = idx_q + 1'b1;
            timer_d = '0;
            lock_d  = 1'b0;
          end
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d == ST_WAIT_PRESS) || (state_d == ST_WAIT_RELEASE);
    game_over_d = (state_d == ST_FAIL);
    pressed_d   = valid_press;
    num_d       = press_num;
  end

  // FSM state, round bookkeeping and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      lock_q      <= 1'b0;
      len_q       <= '0;
      num_q       <= '0;
      pressed_q   <= 1'b0;
      busy_q      <= 1'b0;
      round_ok_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      lock_q      <= lock_d;
      len_q       <= len_d;
      num_q       <= num_d;
      pressed_q   <= pressed_d;
      busy_q      <= busy_d;
      round_ok_q  <= round_ok_d;
      game_over_q <= game_over_d;
    end
  end

  assign seq_rd_addr = idx_q;
  assign num         = num_q;
  assign pressed     = pressed_q;
  assign busy        = busy_q;
  assign round_ok    = round_ok_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100.
// Timing reference: a button vector driven just after edge B becomes the
// stable vector after edge B+6, and the FSM acts on it at edge B+7.
module tb_sequence_checker;

  logic       clk;
  logic       reset;
  logic [3:0] btns;
  logic       start;
  logic [4:0] seq_len;
  logic [3:0] seq_rd_addr;
  logic [1:0] seq_rd_data;
  logic [1:0] num;
  logic       pressed;
  logic       busy;
  logic       round_ok;
  logic       game_over;

  logic [1:0] seq_mem [16];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int rok_cnt   = 0;

  assign seq_rd_data = seq_mem[seq_rd_addr];

  sequence_checker #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btns       (btns),
    .start      (start),
    .seq_len    (seq_len),
    .seq_rd_addr(seq_rd_addr),
    .seq_rd_data(seq_rd_data),
    .num        (num),
    .pressed    (pressed),
    .busy       (busy),
    .round_ok   (round_ok),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge; counts round_ok cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (round_ok === 1'b1) rok_cnt++;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    btns    = 4'b0000;
    start   = 1'b0;
    seq_len = 5'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_start(input logic [4:0] len);
    seq_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic press_release(input logic [3:0] v);
    btns = v;
    repeat (10) tick();
    btns = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    total_cnt++;
    if ({num, pressed, busy, round_ok, game_over, seq_rd_addr} !== 10'd0)
      $display("FAIL reset_outputs: got %b want all zero",
               {num, pressed, busy, round_ok, game_over, seq_rd_addr});
    else pass_cnt++;
    reset = 1'b1;
    repeat (8) tick();
    total_cnt++;
    if ({busy, pressed, game_over} !== 3'b000)
      $display("FAIL reset_idle: busy/pressed/game_over got %b want 000", {busy, pressed, game_over});
    else pass_cnt++;
  endtask

  task automatic test_round_ok();
    int r0;
    do_reset();
    seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd3;
    r0 = rok_cnt;
    pulse_start(5'd3);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL round_start_busy: got %b want 1", busy);
    else pass_cnt++;
    btns = 4'b0100;
    repeat (10) tick();
    total_cnt++;
    if ({pressed, num} !== 3'b1_10) $display("FAIL round_press1: pressed,num got %b want 110", {pressed, num});
    else pass_cnt++;
    btns = 4'b0000;
    repeat (10) tick();
    total_cnt++;
    if (seq_rd_addr !== 4'd1) $display("FAIL round_addr1: got %0d want 1", seq_rd_addr);
    else pass_cnt++;
    press_release(4'b0001);
    total_cnt++;
    if (seq_rd_addr !== 4'd2 || rok_cnt != r0)
      $display("FAIL round_addr2: addr got %0d want 2, round_ok cycles got %0d want 0", seq_rd_addr, rok_cnt - r0);
    else pass_cnt++;
    press_release(4'b1000);
    total_cnt++;
    if (rok_cnt - r0 != 1) $display("FAIL round_ok_pulse: cycles got %0d want 1", rok_cnt - r0);
    else pass_cnt++;
    total_cnt++;
    if ({busy, game_over} !== 2'b00) $display("FAIL round_end: busy,game_over got %b want 00", {busy, game_over});
    else pass_cnt++;
  endtask

  task automatic test_wrong_button();
    do_reset();
    seq_mem[0] = 2'd1;
    pulse_start(5'd1);
    btns = 4'b0100;
    repeat (6) tick();
    total_cnt++;
    if (game_over !== 1'b0) $display("FAIL wrong_early: game_over got %b want 0", game_over);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({game_over, busy} !== 2'b10) $display("FAIL wrong_fail: game_over,busy got %b want 10", {game_over, busy});
    else pass_cnt++;
    btns = 4'b0000;
    repeat (10) tick();
    pulse_start(5'd1);
    tick();
    total_cnt++;
    if ({game_over, busy} !== 2'b10) $display("FAIL wrong_restart: game_over,busy got %b want 10", {game_over, busy});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start(5'd2);
    repeat (99) tick();
    total_cnt++;
    if ({game_over, busy} !== 2'b01) $display("FAIL timeout_before: game_over,busy got %b want 01", {game_over, busy});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({game_over, busy} !== 2'b10) $display("FAIL timeout_expire: game_over,busy got %b want 10", {game_over, busy});
    else pass_cnt++;

    // Press lands in the last timer cycle: the press must win.
    do_reset();
    seq_mem[0] = 2'd3;
    pulse_start(5'd2);
    repeat (93) tick();
    btns = 4'b1000;
    repeat (7) tick();
    total_cnt++;
    if ({game_over, busy, pressed, num} !== 5'b0_1_1_11)
      $display("FAIL timeout_press_wins: game_over,busy,pressed,num got %b want 01111", {game_over, busy, pressed, num});
    else pass_cnt++;
    btns = 4'b0000;
    repeat (10) tick();
    total_cnt++;
    if ({game_over, busy, seq_rd_addr} !== 6'b0_1_0001)
      $display("FAIL timeout_next_step: game_over,busy,addr got %b want 010001", {game_over, busy, seq_rd_addr});
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int bad;
    do_reset();
    seq_mem[0] = 2'd1;
    pulse_start(5'd2);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      btns = ((i >> 1) & 1) ? 4'b0000 : 4'b0010;
      tick();
      if (pressed !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL bounce_pressed: cycles with pressed got %0d want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if ({busy, seq_rd_addr} !== 5'b1_0000) $display("FAIL bounce_state: busy,addr got %b want 10000", {busy, seq_rd_addr});
    else pass_cnt++;
    btns = 4'b0010;
    repeat (10) tick();
    total_cnt++;
    if ({pressed, num} !== 3'b1_01) $display("FAIL settle_press: pressed,num got %b want 101", {pressed, num});
    else pass_cnt++;
    btns = 4'b0011;
    repeat (10) tick();
    total_cnt++;
    if ({pressed, num, busy, seq_rd_addr} !== 8'b0_00_1_0000)
      $display("FAIL multi_button: pressed,num,busy,addr got %b want 00010000", {pressed, num, busy, seq_rd_addr});
    else pass_cnt++;
    btns = 4'b0000;
    repeat (10) tick();
    total_cnt++;
    if (seq_rd_addr !== 4'd1) $display("FAIL multi_release: addr got %0d want 1", seq_rd_addr);
    else pass_cnt++;
  endtask

  task automatic test_lockout_and_invalid();
    int r0;
    do_reset();
    seq_mem[0] = 2'd2;
    pulse_start(5'd0);
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL start_len0: busy got %b want 0", busy);
    else pass_cnt++;
    pulse_start(5'd17);
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL start_len17: busy got %b want 0", busy);
    else pass_cnt++;
    pulse_start(5'd16);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL start_len16: busy got %b want 1", busy);
    else pass_cnt++;

    do_reset();
    btns = 4'b0100;
    repeat (10) tick();
    total_cnt++;
    if ({pressed, num} !== 3'b1_10) $display("FAIL held_idle: pressed,num got %b want 110", {pressed, num});
    else pass_cnt++;
    r0 = rok_cnt;
    pulse_start(5'd1);
    repeat (10) tick();
    btns = 4'b0000;
    repeat (10) tick();
    total_cnt++;
    if (busy !== 1'b1 || rok_cnt != r0)
      $display("FAIL held_lockout: busy got %b want 1, round_ok cycles got %0d want 0", busy, rok_cnt - r0);
    else pass_cnt++;
    btns = 4'b0100;
    repeat (10) tick();
    total_cnt++;
    if ({busy, pressed} !== 2'b11) $display("FAIL after_lockout_press: busy,pressed got %b want 11", {busy, pressed});
    else pass_cnt++;

    // Asynchronous abort while waiting for release.
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({num, pressed, busy, round_ok, game_over, seq_rd_addr} !== 10'd0)
      $display("FAIL async_reset: got %b want all zero",
               {num, pressed, busy, round_ok, game_over, seq_rd_addr});
    else pass_cnt++;
    btns = 4'b0000;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if (rok_cnt != r0 || {busy, game_over} !== 2'b00)
      $display("FAIL abort_no_ok: round_ok cycles got %0d want 0, busy,game_over got %b want 00",
               rok_cnt - r0, {busy, game_over});
    else pass_cnt++;
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b0;
    btns    = 4'b0000;
    start   = 1'b0;
    seq_len = 5'd0;
    for (int i = 0; i < 16; i++) seq_mem[i] = 2'd0;

    test_reset();
    test_round_ok();
    test_wrong_button();
    test_timeout();
    test_bounce();
    test_lockout_and_invalid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
